// File: rtl/peribus_pkg.sv
// Shared types, widths and window decode for the CPU-side peripheral bridge.
// Also used by the peripheral bus controller and the CPU address decoder.
package peribus_pkg;

    localparam int PERI_DATA_W = 16;
    localparam int PERI_ADDR_W = 8;

    localparam logic [15:0] PERI_BASE_DEF    = 16'hFF00;
    localparam logic [15:0] PERI_SPAN_DEF    = 16'h0100;
    localparam logic [15:0] MAPPED_LIMIT_DEF = 16'h0010;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE,
        ERROR
    } peribus_bridge_state_t;

    typedef struct packed {
        logic                   in_window;
        logic                   mapped;
        logic [PERI_ADDR_W-1:0] offset;
    } peri_decode_t;

    // Unsigned wrap-around makes addresses below the base land far outside the window.
    function automatic peri_decode_t peri_decode(
        input logic [15:0] addr,
        input logic [15:0] base  = PERI_BASE_DEF,
        input logic [15:0] span  = PERI_SPAN_DEF,
        input logic [15:0] limit = MAPPED_LIMIT_DEF
    );
        logic [15:0]  diff;
        peri_decode_t d;
        diff        = addr - base;
        d.in_window = (diff < span);
        d.mapped    = (diff < limit);
        d.offset    = diff[PERI_ADDR_W-1:0];
        return d;
    endfunction

endpackage

// File: rtl/peribus_bridge.sv
// CPU-to-peripheral bus bridge: window decode, setup/access/wait sequencing,
// read-data capture and a one-cycle ready/error completion pulse.
//
// state  | meaning
// IDLE   | waiting for cpu_req
// SETUP  | address/data driven, enables low, wait counter loads
// ACCESS | selected enable high for WAIT_STATES+1 cycles
// DONE   | ready pulse, read data presented
// ERROR  | ready pulse with error, bus untouched
module peribus_bridge
    import peribus_pkg::*;
#(
    parameter logic [15:0] PERI_BASE    = PERI_BASE_DEF,
    parameter logic [15:0] PERI_SPAN    = PERI_SPAN_DEF,
    parameter logic [15:0] MAPPED_LIMIT = MAPPED_LIMIT_DEF,
    parameter int          WAIT_STATES  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [15:0]            cpu_addr,
    input  logic [PERI_DATA_W-1:0] cpu_wdata,
    output logic [PERI_DATA_W-1:0] cpu_rdata,
    output logic                   cpu_ready,
    output logic                   cpu_error,
    output logic                   cpu_busy,
    output logic [PERI_ADDR_W-1:0] peri_addr,
    output logic [PERI_DATA_W-1:0] peri_write_data,
    output logic                   peri_write_enable,
    output logic                   peri_read_enable,
    input  logic [PERI_DATA_W-1:0] peri_read_data
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    peribus_bridge_state_t state, state_n;
    logic                   we_q, we_n;
    logic [3:0]             wait_cnt, wait_cnt_n;
    logic [PERI_ADDR_W-1:0] addr_n;
    logic [PERI_DATA_W-1:0] wdata_n, rdata_n;
    logic                   ready_n, error_n, busy_n, wen_n, ren_n;
    peri_decode_t           dec;

    always_comb begin
        state_n    = state;
        we_n       = we_q;
        wait_cnt_n = wait_cnt;
        addr_n     = peri_addr;
        wdata_n    = peri_write_data;
        rdata_n    = '0;
        dec        = peri_decode(cpu_addr, PERI_BASE, PERI_SPAN, MAPPED_LIMIT);

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    we_n = cpu_we;
                    if (dec.in_window && dec.mapped) begin
                        state_n = SETUP;
                        addr_n  = dec.offset;
                        wdata_n = cpu_wdata;
                    end else begin
                        state_n = ERROR;
                    end
                end
            end
            SETUP: begin
                wait_cnt_n = WAIT_LOAD;
                state_n    = ACCESS;
            end
            ACCESS: begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt_n = wait_cnt - 4'd1;
                end else begin
                    state_n = DONE;
                    if (!we_q) rdata_n = peri_read_data;
                end
            end
            DONE:    state_n = IDLE;
            ERROR:   state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        ready_n = (state_n == DONE) || (state_n == ERROR);
        error_n = (state_n == ERROR);
        busy_n  = (state_n != IDLE);
        wen_n   = (state_n == ACCESS) && we_n;
        ren_n   = (state_n == ACCESS) && !we_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            we_q              <= 1'b0;
            wait_cnt          <= 4'd0;
            cpu_rdata         <= '0;
            cpu_ready         <= 1'b0;
            cpu_error         <= 1'b0;
            cpu_busy          <= 1'b0;
            peri_addr         <= '0;
            peri_write_data   <= '0;
            peri_write_enable <= 1'b0;
            peri_read_enable  <= 1'b0;
        end else begin
            state             <= state_n;
            we_q              <= we_n;
            wait_cnt          <= wait_cnt_n;
            cpu_rdata         <= rdata_n;
            cpu_ready         <= ready_n;
            cpu_error         <= error_n;
            cpu_busy          <= busy_n;
            peri_addr         <= addr_n;
            peri_write_data   <= wdata_n;
            peri_write_enable <= wen_n;
            peri_read_enable  <= ren_n;
        end
    end

endmodule

// File: tb/tb_peribus_bridge.sv
// Bench for peribus_bridge: transaction-level model checked every cycle,
// directed literal checks, and a WAIT_STATES=0 instance for latency checks.
module tb_peribus_bridge;

    localparam int          WS    = 1;
    localparam logic [15:0] BASE  = 16'hFF00;
    localparam int          SPAN  = 256;
    localparam int          LIMIT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] peri_read_data = '0;

    logic [15:0] cpu_rdata, peri_write_data;
    logic        cpu_ready, cpu_error, cpu_busy, peri_write_enable, peri_read_enable;
    logic [7:0]  peri_addr;

    logic [15:0] z_rdata, z_wdata;
    logic        z_ready, z_error, z_busy, z_wen, z_ren;
    logic [7:0]  z_addr;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clock = ~clock;

    peribus_bridge #(.WAIT_STATES(WS)) dut (
        .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_error(cpu_error), .cpu_busy(cpu_busy),
        .peri_addr(peri_addr), .peri_write_data(peri_write_data),
        .peri_write_enable(peri_write_enable), .peri_read_enable(peri_read_enable),
        .peri_read_data(peri_read_data)
    );

    peribus_bridge #(.WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(z_rdata),
        .cpu_ready(z_ready), .cpu_error(z_error), .cpu_busy(z_busy),
        .peri_addr(z_addr), .peri_write_data(z_wdata),
        .peri_write_enable(z_wen), .peri_read_enable(z_ren),
        .peri_read_data(peri_read_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted access lives for a fixed number of cycles after the
    // accepting edge; phase 1 is the first cycle after that edge.
    bit          m_active = 1'b0;
    int          m_ph = 0;
    bit          m_err = 1'b0;
    bit          m_we = 1'b0;
    logic [15:0] m_cap = '0;
    logic [7:0]  m_paddr = '0;
    logic [15:0] m_wdata = '0;

    function automatic bit addr_bad(input logic [15:0] a);
        int off;
        off = int'(16'(a - BASE));
        return !(off < SPAN && off < LIMIT);
    endfunction

    function automatic int last_phase(input bit err);
        return err ? 1 : WS + 3;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_active <= 1'b0;
            m_ph     <= 0;
            m_paddr  <= '0;
            m_wdata  <= '0;
            m_cap    <= '0;
        end else if (m_active) begin
            if (!m_err && !m_we && m_ph == WS + 2) m_cap <= peri_read_data;
            if (m_ph == last_phase(m_err)) m_active <= 1'b0;
            else m_ph <= m_ph + 1;
        end else if (cpu_req) begin
            m_active <= 1'b1;
            m_ph     <= 1;
            m_we     <= cpu_we;
            m_err    <= addr_bad(cpu_addr);
            if (!addr_bad(cpu_addr)) begin
                m_paddr <= 8'(cpu_addr - BASE);
                m_wdata <= cpu_wdata;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            automatic bit e_rdy = m_active && (m_ph == last_phase(m_err));
            automatic bit e_acc = m_active && !m_err && (m_ph >= 2) && (m_ph <= WS + 2);
            chk("busy",  32'(cpu_busy),  32'(m_active));
            chk("ready", 32'(cpu_ready), 32'(e_rdy));
            chk("error", 32'(cpu_error), 32'(e_rdy && m_err));
            chk("rdata", 32'(cpu_rdata), (e_rdy && !m_err && !m_we) ? 32'(m_cap) : 32'd0);
            chk("paddr", 32'(peri_addr), 32'(m_paddr));
            chk("pwdata", 32'(peri_write_data), 32'(m_wdata));
            chk("wen",   32'(peri_write_enable), 32'(e_acc && m_we));
            chk("ren",   32'(peri_read_enable),  32'(e_acc && !m_we));
        end
    end

    task automatic run_txn(input bit we, input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] rd, output int rdy1, output int ren1,
                           output int wen1, output logic [15:0] rdat1, output bit err1,
                           output int rdy0, output int en0);
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; peri_read_data = rd;
        rdy1 = 0; ren1 = 0; wen1 = 0; rdat1 = 16'hDEAD; err1 = 1'b0; rdy0 = 0; en0 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            cpu_req = 1'b0;
            if (peri_read_enable) ren1++;
            if (peri_write_enable) wen1++;
            if (cpu_ready && rdy1 == 0) begin
                rdy1 = k; rdat1 = cpu_rdata; err1 = cpu_error;
            end
            if (z_ren || z_wen) en0++;
            if (z_ready && rdy0 == 0) rdy0 = k;
        end
    endtask

    int r1, rn, wn, r0, e0;
    logic [15:0] rdat;
    bit er;
    logic [15:0] err_addrs [3] = '{16'h0100, 16'hFF10, 16'hFFFF};

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_on = 1'b1;
        chk("reset_busy",  32'(cpu_busy), 32'd0);
        chk("reset_rdata", 32'(cpu_rdata), 32'd0);

        run_txn(1'b0, 16'hFF05, 16'h0, 16'hBEEF, r1, rn, wn, rdat, er, r0, e0);
        chk("rd_ready_cyc", 32'(r1), 32'd4);
        chk("rd_ren_cycles", 32'(rn), 32'd2);
        chk("rd_wen_cycles", 32'(wn), 32'd0);
        chk("rd_data", 32'(rdat), 32'hBEEF);
        chk("rd_err", 32'(er), 32'd0);
        chk("rd_paddr", 32'(peri_addr), 32'd5);

        run_txn(1'b1, 16'hFF08, 16'h1234, 16'h5555, r1, rn, wn, rdat, er, r0, e0);
        chk("wr_ready_cyc", 32'(r1), 32'd4);
        chk("wr_wen_cycles", 32'(wn), 32'd2);
        chk("wr_ren_cycles", 32'(rn), 32'd0);
        chk("wr_rdata", 32'(rdat), 32'd0);
        chk("wr_pwdata", 32'(peri_write_data), 32'h1234);

        foreach (err_addrs[i]) begin
            run_txn(1'b0, err_addrs[i], 16'h0, 16'hAAAA, r1, rn, wn, rdat, er, r0, e0);
            chk("err_ready_cyc", 32'(r1), 32'd1);
            chk("err_flag", 32'(er), 32'd1);
            chk("err_rdata", 32'(rdat), 32'd0);
            chk("err_enables", 32'(rn + wn + e0), 32'd0);
        end

        run_txn(1'b0, 16'hFF0C, 16'h0, 16'h0C0C, r1, rn, wn, rdat, er, r0, e0);
        chk("ws0_ready_cyc", 32'(r0), 32'd3);
        chk("ws0_en_cycles", 32'(e0), 32'd1);

        // Held request: accepts every WS+4 cycles.
        begin
            int first = 0, prev = 0, gaps_ok = 1, n = 0;
            @(negedge clock);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF03;
            for (int k = 1; k <= 22; k++) begin
                @(negedge clock);
                if (cpu_ready) begin
                    if (n > 0 && k - prev != WS + 4) gaps_ok = 0;
                    if (n == 0) first = k;
                    prev = k; n++;
                end
            end
            cpu_req = 1'b0;
            chk("held_first_ready", 32'(first), 32'd4);
            chk("held_ready_count", 32'(n), 32'd4);
            chk("held_spacing_ok", 32'(gaps_ok), 32'd1);
            repeat (8) @(negedge clock);
        end

        // Second pulse during ACCESS is dropped.
        begin
            int n = 0;
            @(negedge clock);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF02;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clock);
                cpu_req = (k == 2);
                if (cpu_ready) n++;
            end
            chk("ignored_req_ready_count", 32'(n), 32'd1);
        end

        // Reset in the middle of a write access.
        begin
            int n = 0;
            @(negedge clock);
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF04; cpu_wdata = 16'h7777;
            @(negedge clock);
            cpu_req = 1'b0;
            @(negedge clock);
            chk("rst_pre_wen", 32'(peri_write_enable), 32'd1);
            reset = 1'b1;
            @(negedge clock);
            chk("rst_wen", 32'(peri_write_enable), 32'd0);
            chk("rst_busy", 32'(cpu_busy), 32'd0);
            reset = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                if (cpu_ready) n++;
            end
            chk("rst_no_ready", 32'(n), 32'd0);
            run_txn(1'b0, 16'hFF01, 16'h0, 16'h4321, r1, rn, wn, rdat, er, r0, e0);
            chk("rst_next_ready", 32'(r1), 32'd4);
            chk("rst_next_data", 32'(rdat), 32'h4321);
        end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            cpu_req   = ($urandom % 3) == 0;
            cpu_we    = $urandom % 2;
            cpu_wdata = 16'($urandom);
            peri_read_data = 16'($urandom);
            case ($urandom % 4)
                0: cpu_addr = BASE + 16'($urandom % 32);
                1: cpu_addr = 16'hFFF0 + 16'($urandom % 16);
                2: cpu_addr = 16'($urandom);
                default: cpu_addr = BASE + 16'($urandom % 16);
            endcase
            reset = ($urandom % 97) == 0;
        end
        @(negedge clock);
        reset = 1'b0;
        cpu_req = 1'b0;
        repeat (8) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peribus_bridge.md
Name: peribus_bridge

Overview:
CPU-side bridge that sits directly upstream of the peripheral bus controller. It accepts single-word load/store requests from the CPU memory stage, decodes the peripheral window, and drives the peripheral bus address, write data and enable strobes with a fixed setup/access/wait-state sequence. It captures the returned read data and completes each access with a one-cycle ready pulse. Accesses outside the window or to unmapped peripheral registers complete with an error flag and never touch the bus.

Parameters:
PERI_BASE, 'hFF00, 16-bit CPU base address of the peripheral window; must be 256-aligned.
PERI_SPAN, 'h100, size of the window in words; also the peripheral address space size.
MAPPED_LIMIT, 'h10, peripheral word addresses at or above this value are unmapped.
WAIT_STATES, 1, extra ACCESS cycles beyond the first; legal range 0..15.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
cpu_req  in  1  request strobe; sampled only in IDLE.
cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
cpu_addr  in  16  CPU word address; sampled with cpu_req.
cpu_wdata  in  16  store data; sampled with cpu_req.
cpu_rdata  out  16  load data; valid only while cpu_ready=1.
cpu_ready  out  1  one-cycle completion pulse.
cpu_error  out  1  qualifies cpu_ready: access was out of window or unmapped.
cpu_busy  out  1  high whenever state is not IDLE.
peri_addr  out  8  peripheral word address (cpu_addr - PERI_BASE).
peri_write_data  out  16  registered store data.
peri_write_enable  out  1  write strobe to the peripheral bus.
peri_read_enable  out  1  read strobe to the peripheral bus.
peri_read_data  in  16  read data returned by the peripheral bus controller.

Behaviour:
- Reset: state=IDLE; cpu_rdata=0, cpu_ready=0, cpu_error=0, cpu_busy=0, peri_addr=0, peri_write_data=0, both enables=0, wait counter=0. Reset asserted in any state aborts the access at that edge; no ready pulse is produced for the aborted request.
- All outputs are registered.
- IDLE: when cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata.
  - If (cpu_addr - PERI_BASE) is inside [0, PERI_SPAN) and below MAPPED_LIMIT, go to SETUP and load peri_addr and peri_write_data.
  - Otherwise go to ERROR.
- SETUP: one cycle. Address and data are stable on the bus and both enables are 0. The wait counter loads WAIT_STATES. Go to ACCESS.
- ACCESS:
  - The selected enable is high; peri_write_enable=we and peri_read_enable=!we. The enables are never both high.
  - While the counter is not 0, decrement it and stay in ACCESS.
  - When the counter is 0, sample peri_read_data into the read-data register (reads only) and go to DONE.
  - The enable is high for exactly WAIT_STATES+1 cycles.
- DONE: enables are 0. cpu_ready=1 for this single cycle; cpu_error=0; cpu_rdata holds the captured data for reads and 0 for writes. Go to IDLE.
- ERROR: one cycle with cpu_ready=1, cpu_error=1 and cpu_rdata=0. The enables stay 0 and peri_addr is unchanged. Go to IDLE.
- Latency from the accepting edge to ready: WAIT_STATES+3 cycles for a valid access, 1 cycle for an error.
- cpu_req while not in IDLE is ignored, not queued. A new request may be accepted in the cycle after ready, when the bridge is back in IDLE.
- cpu_rdata and cpu_error return to 0 in the cycle after the ready pulse.
- Address arithmetic is unsigned 16-bit. Addresses below PERI_BASE wrap to large offsets and are therefore out of window. cpu_addr='hFFFF with PERI_BASE='hFF00 gives offset 'hFF, which is inside the window but unmapped, so it returns an error.

Decomposition:
- Shared package peribus_pkg holds:
  - state enum peribus_bridge_state_t {IDLE, SETUP, ACCESS, DONE, ERROR};
  - constants PERI_DATA_W=16 and PERI_ADDR_W=8;
  - default PERI_BASE and MAPPED_LIMIT, reused by the peripheral bus controller and the CPU address decoder.
- No sub-module. The window decode is a single function in the package, peri_decode(addr) returning {in_window, mapped, offset}.

Test Plan:
- Read with WAIT_STATES=1: cpu_addr='hFF05, peri_read_data='hBEEF -> peri_addr=5; peri_read_enable high for 2 cycles; cpu_ready pulses 4 cycles after acceptance with cpu_rdata='hBEEF and cpu_error=0.
- Write: cpu_addr='hFF08, wdata='h1234 -> peri_write_data='h1234 valid from SETUP; peri_write_enable high for exactly 2 cycles; peri_read_enable never high; ready with cpu_rdata=0.
- Errors: cpu_addr='h0100, 'hFF10 and 'hFFFF -> ready and error in the next cycle; cpu_rdata=0; zero enable cycles throughout.
- Back-to-back and ignored requests:
  - cpu_req held high continuously -> a new access is accepted every WAIT_STATES+4 cycles.
  - A second cpu_req pulse during ACCESS produces no extra transaction.
- Reset during ACCESS of a write -> at that edge the enables go to 0 and the bridge is in IDLE; no cpu_ready pulse; the next request completes normally.
- WAIT_STATES=0 build: read of 'hFF0C -> enable high for 1 cycle and ready 3 cycles after acceptance.
